// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle product.
`timescale 1ns/1ps
module execute_muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  E_Start,
    input  logic [2:0]            E_Funct3,
    input  logic [DATA_WIDTH-1:0] E_SrcA,
    input  logic [DATA_WIDTH-1:0] E_SrcB,
    input  logic                  E_Flush,
    output logic                  E_Busy,
    output logic                  E_Done,
    output logic [DATA_WIDTH-1:0] E_Result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_funct3;
    logic            r_neg;
    logic [W-1:0]    r_opb;
    logic [2*W-1:0]  r_acc;
    logic            r_done;
    logic [W-1:0]    r_result;

    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic            w_neg_start;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;
    logic [W-1:0]    w_fast_div;

    always_comb begin
        w_is_div    = E_Funct3[2];
        w_a_signed  = w_is_div ? !E_Funct3[0]
                               : (E_Funct3[1:0] == 2'b01 || E_Funct3[1:0] == 2'b10);
        w_b_signed  = w_is_div ? !E_Funct3[0] : (E_Funct3[1:0] == 2'b01);
        w_sa        = w_a_signed && E_SrcA[W-1];
        w_sb        = w_b_signed && E_SrcB[W-1];
        w_mag_a     = w_sa ? -E_SrcA : E_SrcA;
        w_mag_b     = w_sb ? -E_SrcB : E_SrcB;
        // Remainder sign follows the dividend; everything else takes the XOR of operand signs.
        w_neg_start = (w_is_div && E_Funct3[1]) ? w_sa : (w_sa ^ w_sb);
        w_div_zero  = (E_SrcB == '0);
        w_div_ovf   = !E_Funct3[0] && (E_SrcA == MinVal) && (E_SrcB == '1);
        if (w_div_zero) begin
            w_fast_div = E_Funct3[1] ? E_SrcA : '1;
        end else begin
            w_fast_div = E_Funct3[1] ? '0 : MinVal;
        end
    end

    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_next;
    logic [2*W-1:0]  w_prod_fix;
    logic [W-1:0]    w_mul_res;
    logic [W:0]      w_div_shift;
    logic [W:0]      w_div_diff;
    logic [2*W-1:0]  w_div_next;
    logic [W-1:0]    w_div_val;
    logic [W-1:0]    w_div_res;
    logic            w_last;

    // r_acc: high half is the partial product / remainder, low half the multiplier / dividend.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_next  = {w_mul_sum, r_acc[W-1:1]};
        w_prod_fix  = r_neg ? -w_mul_next : w_mul_next;
        w_mul_res   = (r_funct3 == 2'b00) ? w_prod_fix[W-1:0] : w_prod_fix[2*W-1:W];
        w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        if (w_div_diff[W]) begin
            w_div_next = {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};
        end
        w_div_val   = r_funct3[1] ? w_div_next[2*W-1:W] : w_div_next[W-1:0];
        w_div_res   = r_neg ? -w_div_val : w_div_val;
        w_last      = (r_cnt == CW'(W - 1));
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0]  w_fast_a;
    logic [2*W-1:0]  w_fast_b;
    logic [2*W-1:0]  w_fast_prod;
    logic [W-1:0]    w_fast_mul;

    always_comb begin
        w_fast_a    = {{W{w_sa}}, E_SrcA};
        w_fast_b    = {{W{w_sb}}, E_SrcB};
        w_fast_prod = w_fast_a * w_fast_b;
        w_fast_mul  = (E_Funct3[1:0] == 2'b00) ? w_fast_prod[W-1:0] : w_fast_prod[2*W-1:W];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (E_Flush) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (E_Start) begin
                            r_funct3 <= E_Funct3[1:0];
                            r_neg    <= w_neg_start;
                            r_cnt    <= '0;
                            if (w_is_div) begin
                                r_acc <= {{W{1'b0}}, w_mag_a};
                                r_opb <= w_mag_b;
                                if (w_div_zero || w_div_ovf) begin
                                    r_result <= w_fast_div;
                                    r_done   <= 1'b1;
                                    r_state  <= StDone;
                                end else begin
                                    r_state  <= StDiv;
                                end
                            end else begin
                                r_acc <= {{W{1'b0}}, w_mag_b};
                                r_opb <= w_mag_a;
`ifdef MULDIV_FAST_MUL_EN
                                r_result <= w_fast_mul;
                                r_done   <= 1'b1;
                                r_state  <= StDone;
`else
                                r_state  <= StMul;
`endif
                            end
                        end
                    end
                    StMul: begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_result <= w_mul_res;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end
                    end
                    StDiv: begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_result <= w_div_res;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end
                    end
                    StDone: begin
                        // The completing instruction is still presented, so E_Start is ignored here.
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign E_Busy   = rst_n && ((E_Start && (r_state == StIdle) && !E_Flush)
                                || (r_state == StMul) || (r_state == StDiv));
    assign E_Done   = r_done;
    assign E_Result = r_result;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: cycle-level behavioural model plus directed literals.
`timescale 1ns/1ps
module tb_execute_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulCyc = 1;
`else
    localparam int MulCyc = W + 1;
`endif
    localparam int DivCyc = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          E_Start;
    logic [2:0]    E_Funct3;
    logic [W-1:0]  E_SrcA;
    logic [W-1:0]  E_SrcB;
    logic          E_Flush;
    logic          E_Busy;
    logic          E_Done;
    logic [W-1:0]  E_Result;

    int            n_checks = 0;
    int            n_errors = 0;
    bit            chk_en = 1'b0;

    // Model: phase 0 idle, 1 computing, 2 done.
    int            m_phase = 0;
    int            m_left = 0;
    logic [W-1:0]  m_result = '0;
    logic [W-1:0]  m_pend = '0;

    execute_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E_Start  (E_Start),
        .E_Funct3 (E_Funct3),
        .E_SrcA   (E_SrcA),
        .E_SrcB   (E_SrcB),
        .E_Flush  (E_Flush),
        .E_Busy   (E_Busy),
        .E_Done   (E_Done),
        .E_Result (E_Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int     sa;
        int     sb;
        longint pa;
        longint pb;
        longint p;
        sa = a;
        sb = b;
        if (!f[2]) begin
            if (f == 3'd1 || f == 3'd2) pa = longint'(sa);
            else                        pa = longint'({32'b0, a});
            if (f == 3'd1)              pb = longint'(sb);
            else                        pb = longint'({32'b0, b});
            p = pa * pb;
            if (f == 3'd0) return p[31:0];
            return p[63:32];
        end
        if (b == '0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
        if (!f[0]) return f[1] ? (sa % sb) : (sa / sb);
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        if (f[2]) begin
            if (b == '0) return 1;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return DivCyc;
        end
        return MulCyc;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_left   <= 0;
            m_result <= '0;
        end else if (E_Flush) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (E_Start) begin
                if (ref_lat(E_Funct3, E_SrcA, E_SrcB) == 1) begin
                    m_phase  <= 2;
                    m_result <= ref_op(E_Funct3, E_SrcA, E_SrcB);
                end else begin
                    m_phase <= 1;
                    m_left  <= ref_lat(E_Funct3, E_SrcA, E_SrcB) - 1;
                    m_pend  <= ref_op(E_Funct3, E_SrcA, E_SrcB);
                end
            end
        end else if (m_phase == 1) begin
            if (m_left == 1) begin
                m_phase  <= 2;
                m_result <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(E_Busy),
                  32'(rst_n && ((m_phase == 0 && E_Start && !E_Flush) || m_phase == 1)));
            check("done", 32'(E_Done), 32'(m_phase == 2));
            check("result", E_Result, m_result);
        end
    end

    task automatic start_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        E_Funct3 = f;
        E_SrcA   = a;
        E_SrcB   = b;
        E_Start  = 1'b1;
    endtask

    task automatic run_dir(input string name, input logic [2:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_cyc);
        int cyc;
        check({name, " model"}, ref_op(f, a, b), exp);
        @(posedge clk); #1;
        start_op(f, a, b);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            E_Start = 1'b0;
            cyc++;
        end while (!E_Done && cyc < 60);
        check({name, " cycle"}, 32'(cyc), 32'(exp_cyc));
        check({name, " result"}, E_Result, exp);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run_rand();
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           flush_at;
        int           cyc;
        bit           fin;
        f = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
        flush_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : -1;
        @(posedge clk); #1;
        start_op(f, a, b);
        E_Flush = (flush_at == 0);
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            E_Start = 1'b0;
            E_Flush = (cyc == flush_at);
            if (E_Done) begin
                fin = 1'b1;
            end else if (flush_at >= 0 && cyc > flush_at) begin
                fin = 1'b1;
            end else if (cyc >= 60) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand timeout: no done after %0d cycles, required by %0d", cyc, W + 1);
                fin = 1'b1;
            end
        end
        E_Flush = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  seen_done;
        rst_n    = 1'b0;
        E_Start  = 1'b1;
        E_Flush  = 1'b0;
        E_Funct3 = 3'd0;
        E_SrcA   = '0;
        E_SrcB   = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset result", E_Result, 32'h0);
        check("reset done", 32'(E_Done), 32'h0);
        check("reset busy", 32'(E_Busy), 32'h0);
        @(posedge clk); #1;
        E_Start = 1'b0;
        rst_n   = 1'b1;

        run_dir("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulCyc);
        run_dir("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulCyc);
        run_dir("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulCyc);
        run_dir("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulCyc);
        run_dir("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DivCyc);
        run_dir("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DivCyc);
        run_dir("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_dir("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_dir("DIV by 0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_dir("REM by 0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        run_dir("DIVU by 0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_dir("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_dir("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_dir("DIVU pre", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Flush in cycle 10 of a DIV.
        @(posedge clk); #1;
        start_op(3'd4, 32'd1000, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            E_Start = 1'b0;
        end
        E_Flush = 1'b1;
        @(posedge clk); #1;
        E_Flush = 1'b0;
        check("flush busy", 32'(E_Busy), 32'h0);
        check("flush done", 32'(E_Done), 32'h0);
        check("flush result", E_Result, 32'd14);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (E_Done) seen_done = 1'b1;
        end
        check("flush no done", 32'(seen_done), 32'h0);

        // Start held through DONE must not restart.
        @(posedge clk); #1;
        start_op(3'd5, 32'd100, 32'd7);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!E_Done && cyc < 60);
        check("held cycle", 32'(cyc), 32'd33);
        @(posedge clk); #1;
        E_Start = 1'b0;
        @(posedge clk); #1;
        check("held busy", 32'(E_Busy), 32'h0);
        check("held done", 32'(E_Done), 32'h0);
        run_dir("DIVU fresh", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Reset in cycle 15 of a MUL.
        @(posedge clk); #1;
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            E_Start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst result", E_Result, 32'h0);
        check("rst done", 32'(E_Done), 32'h0);
        check("rst busy", 32'(E_Busy), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst idle busy", 32'(E_Busy), 32'h0);

        for (int i = 0; i < 150; i++) begin
            run_rand();
        end
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Iterative RV32M multiply/divide unit in the Execute stage. It consumes the post-forwarding operands `SrcAE`/`SrcBE`, which are selected by `ForwardAE`/`ForwardBE`. It holds the pipeline through a stall request while it computes, then delivers one result to the Execute result mux. It covers all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).

## Interface
- `DATA_WIDTH`, 32: operand/result width; power of two ≥ 8; iteration counter is $clog2(DATA_WIDTH) bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `E_Start`  in  1  an M-extension instruction is valid in Execute; sampled only in IDLE.
- `E_Funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; latched at start.
- `E_SrcA`, `E_SrcB`  in  DATA_WIDTH  forwarded rs1/rs2 operands; latched at start.
- `E_Flush`  in  1  abort the current operation (branch mispredict/trap).
- `E_Busy`  out  1  stall request to pipeline control.
- `E_Done`  out  1  one-cycle pulse: `E_Result` valid this cycle.
- `E_Result`  out  DATA_WIDTH  registered result; holds until next completion.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, with `E_Start`=1 and `E_Flush`=0:
  - Latch funct3 and operand magnitudes, plus a result-sign flag (signed ops only).
  - MUL-class ops go to MUL; DIV-class ops go to DIV.
  - DIV-class fast paths go straight to DONE:
    - Divide-by-zero: quotient all-ones; remainder = dividend.
    - Signed overflow (-2^(W-1) / -1): quotient = -2^(W-1); remainder 0.
- MUL: shift-add, one multiplier bit per cycle, 2W-bit accumulator, W iterations.
- DIV: restoring divide, one quotient bit per cycle, W iterations.
- On the last iteration, apply sign correction and select the result, then register it into `E_Result` on the edge entering DONE.
  - MUL returns the low W bits.
  - MULH, MULHSU and MULHU return the high W bits.
  - MULHSU treats only rs1 as signed.
  - Remainder sign follows the dividend; quotient sign = sign(A) XOR sign(B).
- DONE: `E_Done`=1, `E_Busy`=0 so the pipeline advances; always returns to IDLE next edge.
  - `E_Start` is ignored in DONE, because the completing instruction is still presented.
- `E_Flush`=1 in any state: go to IDLE next edge, no `E_Done`, `E_Result` unchanged.
  - Flush wins over a simultaneous `E_Start`.
- `E_Busy` = `E_Start`&&IDLE&&!`E_Flush` || state∈{MUL,DIV}. It is combinational, so Execute stalls in the start cycle itself.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `E_Done`=0, `E_Result`=0, counter 0. `E_Busy` is forced 0 while `rst_n`=0.
- Reset mid-operation aborts it with no `E_Done`.
- Start accepted at the edge ending cycle 0.
- Iterative MUL/DIV:
  - MUL or DIV occupies cycles 1..W.
  - DONE in cycle W+1, so `E_Done` is in cycle 33 for W=32.
  - `E_Busy` is high cycles 0..W.
- Fast-path DIV: DONE in cycle 1; `E_Busy` high in cycle 0 only.
- Back-to-back ops: the next `E_Start` is accepted in IDLE, at the earliest in cycle W+2.
- Throughput: one operation per W+2 cycles (iterative).

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL-class ops use a single-cycle 2W-bit combinational product registered into `E_Result`.
  - IDLE goes directly to DONE, so `E_Done` is in cycle 1; the MUL state is unused.
- `MULDIV_FAST_MUL_EN` undefined: iterative shift-add multiplier as above.
- Division is always iterative.

## Test plan
- MUL 7 × 0xFFFFFFFD:
  - `E_Result`=0xFFFFFFEB; `E_Done` in cycle 33, or cycle 1 with `MULDIV_FAST_MUL_EN`.
  - `E_Busy` high cycles 0..32, or cycle 0 only with `MULDIV_FAST_MUL_EN`.
- High-half products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2; `E_Done` in cycle 33.
- Fast paths:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU 5/0 → 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All complete with `E_Done` in cycle 1.
- Flush and held start:
  - `E_Flush` in cycle 10 of a DIV → IDLE next edge, no `E_Done`, `E_Result` keeps its previous value.
  - `E_Start` held through DONE does not restart; a fresh start after IDLE completes normally.
- `rst_n`=0 in cycle 15 of a MUL → next cycle IDLE, `E_Result`=0, `E_Done`=0, `E_Busy`=0.
